// File: rtl/rvga_mem_responder.sv
// rtl/rvga_mem_responder.sv - word-addressed instruction/data memory responder with fixed-latency per-port FSMs
// Define RVGA_MEM_BYTE_EN to add the dmem_be_i byte-enable port for data writes.
module rvga_mem_responder #(
  parameter int DEPTH   = 4096,
  parameter int LATENCY = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] imem_addr_i,
  output logic [31:0] imem_data_o,
  output logic        imem_resp_v_o,
  input  logic        dmem_r_v_i,
  input  logic        dmem_w_v_i,
  input  logic [31:0] dmem_addr_i,
  input  logic [31:0] dmem_data_i,
`ifdef RVGA_MEM_BYTE_EN
  input  logic [3:0]  dmem_be_i,
`endif
  output logic [31:0] dmem_data_o,
  output logic        dmem_resp_v_o
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_RESP} state_t;
  localparam state_t ST_ACCEPT = (LATENCY == 1) ? S_RESP : S_BUSY;

  logic [31:0] r_mem [DEPTH];

  state_t      r_i_state, w_i_state_nx;
  logic [3:0]  r_i_cnt, w_i_cnt_nx;
  logic        w_i_accept;
  logic [31:2] r_i_addr;
  logic [31:0] r_i_hold;

  state_t      r_d_state, w_d_state_nx;
  logic [3:0]  r_d_cnt, w_d_cnt_nx;
  logic        w_d_accept;
  logic [31:2] r_d_addr;
  logic [31:0] r_d_wdata;
  logic        r_d_we;
  logic [3:0]  r_d_be;
  logic [31:0] r_d_hold;

  logic          w_i_oor, w_d_oor, w_d_commit;
  logic [AW-1:0] w_i_idx, w_d_idx;
  logic [31:0]   w_i_rdata, w_d_rdata;
  logic [3:0]    w_be_in;
  logic          w_unused;

`ifdef RVGA_MEM_BYTE_EN
  assign w_be_in = dmem_be_i;
`else
  assign w_be_in = 4'hF;
`endif
  assign w_unused = ^{imem_addr_i[1:0], dmem_addr_i[1:0]};

  // Array reads happen combinationally in RESP so a write committing at the same edge is seen.
  assign w_i_oor   = |r_i_addr[31:AW+2];
  assign w_i_idx   = r_i_addr[AW+1:2];
  assign w_i_rdata = w_i_oor ? 32'h0 : r_mem[w_i_idx];
  assign w_d_oor   = |r_d_addr[31:AW+2];
  assign w_d_idx   = r_d_addr[AW+1:2];
  assign w_d_rdata = w_d_oor ? 32'h0 : r_mem[w_d_idx];
  assign w_d_commit = (r_d_state == S_RESP) && r_d_we && !w_d_oor;

  always_comb begin
    w_i_state_nx = r_i_state;
    w_i_cnt_nx   = r_i_cnt;
    w_i_accept   = 1'b0;
    case (r_i_state)
      S_IDLE: begin
        w_i_accept   = 1'b1;
        w_i_cnt_nx   = CNT_INIT;
        w_i_state_nx = ST_ACCEPT;
      end
      S_BUSY: begin
        w_i_cnt_nx = r_i_cnt - 4'd1;
        if (r_i_cnt == 4'd1) w_i_state_nx = S_RESP;
      end
      S_RESP:  w_i_state_nx = S_IDLE;
      default: w_i_state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    w_d_state_nx = r_d_state;
    w_d_cnt_nx   = r_d_cnt;
    w_d_accept   = 1'b0;
    case (r_d_state)
      S_IDLE: begin
        if (dmem_r_v_i || dmem_w_v_i) begin
          w_d_accept   = 1'b1;
          w_d_cnt_nx   = CNT_INIT;
          w_d_state_nx = ST_ACCEPT;
        end
      end
      S_BUSY: begin
        w_d_cnt_nx = r_d_cnt - 4'd1;
        if (r_d_cnt == 4'd1) w_d_state_nx = S_RESP;
      end
      S_RESP:  w_d_state_nx = S_IDLE;
      default: w_d_state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      r_i_state <= S_IDLE;
      r_i_cnt   <= 4'd0;
      r_i_addr  <= '0;
      r_i_hold  <= 32'h0;
    end else begin
      r_i_state <= w_i_state_nx;
      r_i_cnt   <= w_i_cnt_nx;
      if (w_i_accept) r_i_addr <= imem_addr_i[31:2];
      if (r_i_state == S_RESP) r_i_hold <= w_i_rdata;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      r_d_state <= S_IDLE;
      r_d_cnt   <= 4'd0;
      r_d_addr  <= '0;
      r_d_wdata <= 32'h0;
      r_d_we    <= 1'b0;
      r_d_be    <= 4'h0;
      r_d_hold  <= 32'h0;
    end else begin
      r_d_state <= w_d_state_nx;
      r_d_cnt   <= w_d_cnt_nx;
      if (w_d_accept) begin
        r_d_addr  <= dmem_addr_i[31:2];
        r_d_wdata <= dmem_data_i;
        r_d_we    <= dmem_w_v_i;
        r_d_be    <= w_be_in;
      end
      if (r_d_state == S_RESP) r_d_hold <= w_d_rdata;
    end
  end

  // No reset on the array: contents survive rst_i, only the in-flight commit is gated.
  always_ff @(posedge clk_i) begin
    if (rst_i && w_d_commit) begin
      for (int b = 0; b < 4; b++) begin
        if (r_d_be[b]) r_mem[w_d_idx][8*b +: 8] <= r_d_wdata[8*b +: 8];
      end
    end
  end

  assign imem_resp_v_o = (r_i_state == S_RESP);
  assign imem_data_o   = imem_resp_v_o ? w_i_rdata : r_i_hold;
  assign dmem_resp_v_o = (r_d_state == S_RESP);
  assign dmem_data_o   = dmem_resp_v_o ? w_d_rdata : r_d_hold;
endmodule

// File: doc/rvga_mem_responder.md
Name: rvga_mem_responder

Overview:
- Memory-side responder for the core's instruction and data interfaces.
- Presents a word-addressed backing store with a read-only instruction port and a read/write data port.
- Each port has a per-port FSM with programmable response latency.
- Used as the core's memory in simulation and FPGA builds, and drives the core's resp-valid stall signals.

Parameters:
- DEPTH, 4096: number of 32-bit words in the backing store; power of two.
- LATENCY, 2: cycles from request acceptance to the response pulse; legal range 1..15.

Ports:
- clk_i  input  1  clock.
- rst_i  input  1  reset; synchronous, active-low.
- imem_addr_i  input  32  instruction fetch byte address; the core treats a read as always requested.
- imem_data_o  output  32  fetched instruction word.
- imem_resp_v_o  output  1  one-cycle pulse; imem_data_o is valid this cycle.
- dmem_r_v_i  input  1  data read request.
- dmem_w_v_i  input  1  data write request.
- dmem_addr_i  input  32  data byte address.
- dmem_data_i  input  32  write data from the core.
- dmem_data_o  output  32  read data to the core.
- dmem_resp_v_o  output  1  one-cycle pulse; read data valid / write committed.

Behaviour:
- Reset (rst_i low at posedge):
  - Both FSMs go to IDLE; counters are cleared.
  - imem_resp_v_o = 0, dmem_resp_v_o = 0, imem_data_o = 0, dmem_data_o = 0.
  - Array contents are preserved.
  - Reset mid-operation abandons the pending access with no response; a pending write is not committed.
- Addressing:
  - Word index = addr[log2(DEPTH)+1:2]; addr[1:0] is ignored.
  - Any address >= DEPTH*4 is out-of-range: reads return 32'h0, writes are dropped, and a response is still issued at normal latency.
- Per-port FSM, states IDLE, BUSY, RESP:
  - IDLE: imem always accepts. dmem accepts when r_v or w_v is high. On accept, latch address, write data and request type, load the counter with LATENCY-1, then go to BUSY, or straight to RESP if LATENCY = 1.
  - BUSY: decrement the counter; go to RESP when it reaches 0.
  - RESP: assert resp_v for exactly one cycle with the data valid, then return to IDLE.
  - The response pulse falls LATENCY cycles after the accept edge.
  - Throughput is one access per LATENCY+1 cycles per port.
- Inputs are sampled only in IDLE. Changes during BUSY/RESP are ignored; the core holds them stable anyway.
- Read data is read from the array in the RESP cycle. Data outputs hold their last value outside RESP.
- Write is committed at the end of the RESP cycle. dmem_data_o in a write RESP returns the pre-write word.
- Both dmem_r_v_i and dmem_w_v_i high: treated as a write.
- Same-word collision (imem RESP and dmem write RESP in the same cycle): imem returns the old word; the new value is visible from the next access.
- The two ports are fully independent; there is no arbitration and no backpressure beyond resp_v.

Optional Feature:
- Macro RVGA_MEM_BYTE_EN.
- When defined:
  - Adds port dmem_be_i (input, 4 bits), latched on accept with the write request.
  - On a write commit, only bytes with be[n] = 1 are updated. be = 4'b0000 still responds but writes nothing.
  - Reads ignore dmem_be_i.
- When undefined:
  - The port is absent and every write updates all 4 bytes.

Test Plan:
- Reset with rst_i=0 for 2 cycles, hold imem_addr_i=0 -> both resp_v low during reset; first imem_resp_v_o pulse exactly LATENCY=2 cycles after the first posedge with rst_i=1; data = mem[0].
- Write 32'hDEADBEEF to 32'h10, then read 32'h10 -> write resp after 2 cycles with dmem_data_o = old word; read resp returns 32'hDEADBEEF; resp_v high for exactly 1 cycle each.
- Out-of-range read at DEPTH*4 = 32'h4000 -> dmem_resp_v_o after LATENCY cycles with data 32'h0. Write 32'h1234 to 32'h4000 -> no array word changes.
- Same-cycle imem fetch and dmem write to 32'h20 (old 32'h1111, new 32'h2222) -> imem returns 32'h1111; next fetch of 32'h20 returns 32'h2222.
- Assert rst_i=0 while the dmem write to 32'h30 is in BUSY -> no dmem_resp_v_o; mem[0x30>>2] unchanged after reset.
- With RVGA_MEM_BYTE_EN: mem[0x40]=32'hAABBCCDD, write 32'h11223344 with be=4'b0101 -> read returns 32'hAA22CC44.
